// File: rtl/img_buf_pkg.sv
// Shared constants and types for the image receive buffer.
// The BNN interface takes its image width from here as well.
package img_buf_pkg;

  localparam int IMG_BITS  = 904;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = IMG_BITS / BYTE_W;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam int IDX_W     = $clog2(IMG_BITS);

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } img_buf_state_t;

  // Lowest bit of slot k; slot 0 sits at the MSB end.
  function automatic int slot_lo(input int k);
    return (NUM_BYTES - 1 - k) * BYTE_W;
  endfunction

endpackage

// File: rtl/image_rx_buffer_if.sv
// Byte-stream in, image word and status out.
// master = producer/consumer side, slave = the buffer.
interface img_rx_if;
  import img_buf_pkg::*;

  logic [BYTE_W-1:0]   rx_byte;
  logic                rx_valid;
  logic                rx_ready;
  logic                buffer_clear;
  logic [IMG_BITS-1:0] img_out;
  logic                img_buffer_full;
  logic [CNT_W-1:0]    byte_count;
  logic                overflow;

  modport master (
    output rx_byte,
    output rx_valid,
    output buffer_clear,
    input  rx_ready,
    input  img_out,
    input  img_buffer_full,
    input  byte_count,
    input  overflow
  );

  modport slave (
    input  rx_byte,
    input  rx_valid,
    input  buffer_clear,
    output rx_ready,
    output img_out,
    output img_buffer_full,
    output byte_count,
    output overflow
  );

endinterface

// File: rtl/image_rx_buffer.sv
// Packs a serial byte stream MSB-first into one image word.
// Holds the frame once full until cleared; tracks overflow.
module image_rx_buffer
  import img_buf_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  img_rx_if.slave bus
);

  if (IMG_BITS % BYTE_W != 0) begin : g_width_chk
    $error("IMG_BITS must be a multiple of BYTE_W");
  end

  img_buf_state_t      r_state;
  logic [IMG_BITS-1:0] r_img;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_full;
  logic                r_ovf;

  logic [IDX_W-1:0]    w_lo;
  logic                w_last;

  assign w_lo   = IDX_W'(slot_lo(int'(r_cnt)));
  assign w_last = (r_cnt == CNT_W'(NUM_BYTES - 1));

  // Clear outranks any byte strobe in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILLING;
      r_img   <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.buffer_clear) begin
      r_state <= FILLING;
      r_img   <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        FILLING: begin
          if (bus.rx_valid) begin
            r_img[w_lo +: BYTE_W] <= bus.rx_byte;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= FULL;
              r_full  <= 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.rx_valid) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          r_state <= FILLING;
        end
      endcase
    end
  end

  assign bus.rx_ready        = (r_state == FILLING);
  assign bus.img_out         = r_img;
  assign bus.img_buffer_full = r_full;
  assign bus.byte_count      = r_cnt;
  assign bus.overflow        = r_ovf;

endmodule
